// File: rtl/xnor_popcount_threshold_if.sv
// ---------------------------------------------------------------------------
// xnor_popcount_threshold_if
// Bundles the streaming signals of the XNOR popcount/threshold block.
//   in_V_TDATA   : XNOR product word, SIMD bits
//   in_V_TVALID  : input beat valid
//   in_V_TREADY  : input beat accepted when TVALID && TREADY
//   thr_V        : per-neuron threshold, taken with the first beat
//   out_V_TDATA  : activation bit (acc >= threshold)
//   out_acc      : raw popcount total of the neuron
//   out_V_TVALID : result valid
//   out_V_TREADY : downstream accepts result
//   busy         : work in flight
// master = producer/consumer environment, slave = the threshold block.
// ---------------------------------------------------------------------------
interface xnor_popcount_threshold_if #(
    parameter int SIMD  = 288,
    parameter int ACC_W = 12
);
    logic [SIMD-1:0]  in_V_TDATA;
    logic             in_V_TVALID;
    logic             in_V_TREADY;
    logic [ACC_W-1:0] thr_V;
    logic             out_V_TDATA;
    logic [ACC_W-1:0] out_acc;
    logic             out_V_TVALID;
    logic             out_V_TREADY;
    logic             busy;

    modport master (
        output in_V_TDATA, in_V_TVALID, thr_V, out_V_TREADY,
        input  in_V_TREADY, out_V_TDATA, out_acc, out_V_TVALID, busy
    );

    modport slave (
        input  in_V_TDATA, in_V_TVALID, thr_V, out_V_TREADY,
        output in_V_TREADY, out_V_TDATA, out_acc, out_V_TVALID, busy
    );
endinterface

// File: rtl/xnor_popcount_threshold.sv
// ---------------------------------------------------------------------------
// xnor_popcount_threshold
// Popcounts FOLD XNOR product words of one neuron, accumulates them and
// compares the total against the neuron threshold (unsigned, inclusive).
// Two-stage pipeline: stage 1 registers per-chunk partial popcounts,
// stage 2 sums them into the accumulator and loads the output register.
// A pending, unaccepted result freezes the whole pipeline.
// Ports:
//   ap_clk : clock, rising edge
//   ap_rst : synchronous active-high reset
//   bus    : xnor_popcount_threshold_if.slave (streams, threshold, busy)
// ---------------------------------------------------------------------------
module xnor_popcount_threshold #(
    parameter int SIMD  = 288,
    parameter int FOLD  = 9,
    parameter int CHUNK = 32,
    parameter int ACC_W = 12
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    xnor_popcount_threshold_if.slave     bus
);
    localparam int NCHUNK = (SIMD + CHUNK - 1) / CHUNK;
    localparam int PAD_W  = NCHUNK * CHUNK;
    localparam int PC_W   = $clog2(CHUNK + 1);
    localparam int FC_W   = (FOLD > 1) ? $clog2(FOLD) : 1;

    // Popcount of one CHUNK-wide slice (the tail slice is zero padded).
    function automatic logic [PC_W-1:0] chunk_popcount(input logic [CHUNK-1:0] slice);
        logic [PC_W-1:0] cnt;
        cnt = {PC_W{1'b0}};
        for (int b = 0; b < CHUNK; b++) begin
            cnt = cnt + PC_W'(slice[b]);
        end
        return cnt;
    endfunction

    logic [FC_W-1:0]  fold_cnt_r;
    logic             s1_valid_r;
    logic             s1_first_r;
    logic             s1_last_r;
    logic [PC_W-1:0]  s1_part_r [NCHUNK];
    logic [ACC_W-1:0] thr_q_r;
    logic [ACC_W-1:0] acc_r;
    logic             out_valid_r;
    logic             out_bit_r;
    logic [ACC_W-1:0] out_acc_r;

    logic             en_s;
    logic             accept_s;
    logic             first_s;
    logic             last_s;
    logic [PAD_W-1:0] padded_s;
    logic [PC_W-1:0]  partial_s [NCHUNK];
    logic [ACC_W-1:0] sum_s;
    logic [ACC_W-1:0] acc_next_s;

    // Handshake: the pipeline advances only when the output slot is free or draining.
    always_comb begin
        en_s     = !out_valid_r || bus.out_V_TREADY;
        accept_s = bus.in_V_TVALID && en_s && !ap_rst;
        first_s  = (fold_cnt_r == {FC_W{1'b0}});
        last_s   = (fold_cnt_r == FC_W'(FOLD - 1));
    end

    // Stage-1 combinational partial popcounts of the incoming word.
    always_comb begin
        padded_s = PAD_W'(bus.in_V_TDATA);
        for (int c = 0; c < NCHUNK; c++) begin
            partial_s[c] = chunk_popcount(padded_s[c*CHUNK +: CHUNK]);
        end
    end

    // Stage-2 combinational sum of partials and next accumulator value.
    always_comb begin
        sum_s = {ACC_W{1'b0}};
        for (int c = 0; c < NCHUNK; c++) begin
            sum_s = sum_s + ACC_W'(s1_part_r[c]);
        end
        if (s1_first_r) begin
            acc_next_s = sum_s;
        end else begin
            acc_next_s = acc_r + sum_s;
        end
    end

    // Pipeline state: fold counter, stage-1 registers, accumulator and output register.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            fold_cnt_r  <= {FC_W{1'b0}};
            s1_valid_r  <= 1'b0;
            s1_first_r  <= 1'b0;
            s1_last_r   <= 1'b0;
            thr_q_r     <= {ACC_W{1'b0}};
            acc_r       <= {ACC_W{1'b0}};
            out_valid_r <= 1'b0;
            out_bit_r   <= 1'b0;
            out_acc_r   <= {ACC_W{1'b0}};
            for (int c = 0; c < NCHUNK; c++) begin
                s1_part_r[c] <= {PC_W{1'b0}};
            end
        end else if (en_s) begin
            if (accept_s) begin
                fold_cnt_r <= last_s ? {FC_W{1'b0}} : fold_cnt_r + FC_W'(1'b1);
                s1_valid_r <= 1'b1;
                s1_first_r <= first_s;
                s1_last_r  <= last_s;
                for (int c = 0; c < NCHUNK; c++) begin
                    s1_part_r[c] <= partial_s[c];
                end
                // Threshold is latched once per neuron; later changes of thr_V are ignored.
                if (first_s) begin
                    thr_q_r <= bus.thr_V;
                end else begin
                    thr_q_r <= thr_q_r;
                end
            end else begin
                s1_valid_r <= 1'b0;
            end

            if (s1_valid_r && s1_last_r) begin
                out_acc_r   <= acc_next_s;
                out_bit_r   <= (acc_next_s >= thr_q_r);
                out_valid_r <= 1'b1;
                acc_r       <= {ACC_W{1'b0}};
            end else begin
                if (s1_valid_r) begin
                    acc_r <= acc_next_s;
                end else begin
                    acc_r <= acc_r;
                end
                // en_s implies the held result (if any) is being taken this edge.
                out_valid_r <= 1'b0;
            end
        end else begin
            fold_cnt_r <= fold_cnt_r;
        end
    end

    assign bus.in_V_TREADY  = en_s && !ap_rst;
    assign bus.out_V_TVALID = out_valid_r;
    assign bus.out_V_TDATA  = out_bit_r;
    assign bus.out_acc      = out_acc_r;
    assign bus.busy         = !ap_rst && ((fold_cnt_r != {FC_W{1'b0}}) || s1_valid_r || out_valid_r);
endmodule

// File: tb/tb_xnor_popcount_threshold.sv
// ---------------------------------------------------------------------------
// tb_xnor_popcount_threshold
// Scenario tasks drive the block and compare against a neuron-level model:
// each neuron's expected total is the sum of $countones over the FOLD
// accepted beats, and the bit is total >= threshold seen on the first beat.
// A second instance built with FOLD=1 covers the single-beat neuron case.
// ---------------------------------------------------------------------------
module tb_xnor_popcount_threshold;
    localparam int SIMD  = 288;
    localparam int FOLD  = 9;
    localparam int ACC_W = 12;

    logic ap_clk = 1'b0;
    logic ap_rst;
    always #5 ap_clk = ~ap_clk;

    xnor_popcount_threshold_if #(.SIMD(SIMD), .ACC_W(ACC_W)) bus ();
    xnor_popcount_threshold_if #(.SIMD(SIMD), .ACC_W(ACC_W)) bus1 ();

    xnor_popcount_threshold #(.SIMD(SIMD), .FOLD(FOLD), .CHUNK(32), .ACC_W(ACC_W)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus)
    );
    xnor_popcount_threshold #(.SIMD(SIMD), .FOLD(1), .CHUNK(32), .ACC_W(ACC_W)) dut1 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus1)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [SIMD-1:0] ones_w;
    logic [SIMD-1:0] zero_w;
    logic [SIMD-1:0] half_w;

    // neuron-level reference model and result collection
    int               m_acc = 0;
    int               m_beats = 0;
    int               m_thr = 0;
    logic [ACC_W-1:0] exp_acc[$];
    logic             exp_bit[$];
    logic [ACC_W-1:0] got_acc[$];
    logic             got_bit[$];
    bit               accepted;

    // One clock: observe handshakes at the falling edge, return 1ns after rising edge.
    task automatic tick();
        @(negedge ap_clk);
        accepted = 1'b0;
        if (ap_rst) begin
            m_acc = 0;
            m_beats = 0;
        end else if (bus.in_V_TVALID && bus.in_V_TREADY) begin
            accepted = 1'b1;
            if (m_beats == 0) m_thr = int'(bus.thr_V);
            m_acc += $countones(bus.in_V_TDATA);
            m_beats++;
            if (m_beats == FOLD) begin
                exp_acc.push_back(ACC_W'(m_acc));
                exp_bit.push_back(m_acc >= m_thr);
                m_acc = 0;
                m_beats = 0;
            end
        end
        if (!ap_rst && bus.out_V_TVALID && bus.out_V_TREADY) begin
            got_acc.push_back(bus.out_acc);
            got_bit.push_back(bus.out_V_TDATA);
        end
        @(posedge ap_clk);
        #1;
    endtask

    // Let the pipeline empty with the consumer always ready (bounded).
    task automatic drain();
        bus.in_V_TVALID = 1'b0;
        bus.out_V_TREADY = 1'b1;
        for (int i = 0; i < 40 && (got_acc.size() < exp_acc.size() || bus.out_V_TVALID || bus.busy); i++) tick();
    endtask

    task automatic test_reset();
        ap_rst = 1'b1;
        bus.in_V_TVALID = 1'b0; bus.in_V_TDATA = zero_w; bus.thr_V = 12'd0; bus.out_V_TREADY = 1'b0;
        bus1.in_V_TVALID = 1'b0; bus1.in_V_TDATA = zero_w; bus1.thr_V = 12'd0; bus1.out_V_TREADY = 1'b0;
        tick(); tick();
        vectors++; if (bus.out_V_TVALID !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", bus.out_V_TVALID); end
        vectors++; if (bus.out_acc !== 12'd0) begin miscompares++; $display("FAIL reset_acc got=%0d exp=0", bus.out_acc); end
        vectors++; if (bus.out_V_TDATA !== 1'b0) begin miscompares++; $display("FAIL reset_bit got=%b exp=0", bus.out_V_TDATA); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        vectors++; if (bus.in_V_TREADY !== 1'b0) begin miscompares++; $display("FAIL reset_tready got=%b exp=0", bus.in_V_TREADY); end
        ap_rst = 1'b0;
        tick();
        vectors++; if (bus.in_V_TREADY !== 1'b1) begin miscompares++; $display("FAIL post_reset_tready got=%b exp=1", bus.in_V_TREADY); end
    endtask

    task automatic test_all_ones();
        bus.out_V_TREADY = 1'b1; bus.thr_V = 12'd2592; bus.in_V_TDATA = ones_w;
        for (int b = 0; b < FOLD; b++) begin
            bus.in_V_TVALID = 1'b1;
            tick();
            vectors++; if (!accepted) begin miscompares++; $display("FAIL ones_accept beat=%0d got=0 exp=1", b); end
        end
        bus.in_V_TVALID = 1'b0;
        vectors++; if (bus.out_V_TVALID !== 1'b0) begin miscompares++; $display("FAIL ones_early_valid got=%b exp=0", bus.out_V_TVALID); end
        tick();
        vectors++; if (bus.out_V_TVALID !== 1'b1) begin miscompares++; $display("FAIL ones_latency got=%b exp=1", bus.out_V_TVALID); end
        vectors++; if (bus.out_acc !== 12'd2592 || bus.out_V_TDATA !== 1'b1) begin
            miscompares++; $display("FAIL ones_result got=%0d/%b exp=2592/1", bus.out_acc, bus.out_V_TDATA);
        end
        drain();
        while (exp_acc.size() > 0) begin
            logic [ACC_W-1:0] ea; logic eb;
            ea = exp_acc.pop_front(); eb = exp_bit.pop_front();
            vectors++;
            if (got_acc.size() == 0) begin miscompares++; $display("FAIL ones_missing got=none exp=%0d/%b", ea, eb); end
            else begin
                logic [ACC_W-1:0] ga; logic gb;
                ga = got_acc.pop_front(); gb = got_bit.pop_front();
                if (ga !== ea || gb !== eb) begin miscompares++; $display("FAIL ones_model got=%0d/%b exp=%0d/%b", ga, gb, ea, eb); end
            end
        end
        got_acc.delete(); got_bit.delete();
    endtask

    task automatic test_zero();
        logic [ACC_W-1:0] ka [2];
        logic             kb [2];
        ka[0] = 12'd0; kb[0] = 1'b1; ka[1] = 12'd0; kb[1] = 1'b0;
        bus.out_V_TREADY = 1'b1; bus.in_V_TDATA = zero_w;
        for (int n = 0; n < 2; n++) begin
            bus.thr_V = (n == 0) ? 12'd0 : 12'd1;
            for (int b = 0; b < FOLD; b++) begin bus.in_V_TVALID = 1'b1; tick(); end
        end
        drain();
        for (int n = 0; n < 2; n++) begin
            vectors++;
            if (got_acc.size() == 0 || exp_acc.size() == 0) begin miscompares++; $display("FAIL zero_missing n=%0d got=none exp=%0d/%b", n, ka[n], kb[n]); end
            else begin
                logic [ACC_W-1:0] ga, ea; logic gb, eb;
                ga = got_acc.pop_front(); gb = got_bit.pop_front();
                ea = exp_acc.pop_front(); eb = exp_bit.pop_front();
                if (ga !== ka[n] || gb !== kb[n] || ga !== ea || gb !== eb)
                    begin miscompares++; $display("FAIL zero_result n=%0d got=%0d/%b exp=%0d/%b", n, ga, gb, ka[n], kb[n]); end
            end
        end
        exp_acc.delete(); exp_bit.delete(); got_acc.delete(); got_bit.delete();
    endtask

    task automatic test_back_to_back();
        logic [ACC_W-1:0] ka [2];
        logic             kb [2];
        int               stalls;
        ka[0] = 12'd1296; kb[0] = 1'b1; ka[1] = 12'd1296; kb[1] = 1'b0;
        stalls = 0;
        bus.out_V_TREADY = 1'b1; bus.in_V_TDATA = half_w;
        for (int i = 0; i < 2 * FOLD; i++) begin
            // threshold moves mid-neuron; only the first-beat value may count
            if (i == 0) bus.thr_V = 12'd1296;
            else if (i == FOLD) bus.thr_V = 12'd1297;
            else bus.thr_V = ACC_W'($urandom_range(0, 4095));
            bus.in_V_TVALID = 1'b1;
            tick();
            if (!accepted) stalls++;
        end
        vectors++; if (stalls != 0) begin miscompares++; $display("FAIL b2b_stalls got=%0d exp=0", stalls); end
        drain();
        for (int n = 0; n < 2; n++) begin
            vectors++;
            if (got_acc.size() == 0 || exp_acc.size() == 0) begin miscompares++; $display("FAIL b2b_missing n=%0d got=none exp=%0d/%b", n, ka[n], kb[n]); end
            else begin
                logic [ACC_W-1:0] ga, ea; logic gb, eb;
                ga = got_acc.pop_front(); gb = got_bit.pop_front();
                ea = exp_acc.pop_front(); eb = exp_bit.pop_front();
                if (ga !== ka[n] || gb !== kb[n] || ga !== ea || gb !== eb)
                    begin miscompares++; $display("FAIL b2b_result n=%0d got=%0d/%b exp=%0d/%b", n, ga, gb, ka[n], kb[n]); end
            end
        end
        exp_acc.delete(); exp_bit.delete(); got_acc.delete(); got_bit.delete();
    endtask

    task automatic test_backpressure();
        int b, stalls, cycles;
        logic [ACC_W-1:0] ka [2];
        ka[0] = 12'd2592; ka[1] = 12'd288;
        bus.out_V_TREADY = 1'b0; bus.thr_V = 12'd2592; bus.in_V_TDATA = ones_w;
        for (int i = 0; i < FOLD; i++) begin bus.in_V_TVALID = 1'b1; tick(); end
        b = 0; stalls = 0; cycles = 0;
        while (b < FOLD && cycles < 200) begin
            bus.in_V_TVALID = 1'b1;
            bus.in_V_TDATA = (b == 0) ? ones_w : zero_w;
            bus.thr_V = (b == 0) ? 12'd200 : ACC_W'($urandom_range(0, 4095));
            if (bus.out_V_TVALID && !bus.out_V_TREADY) begin
                stalls++;
                vectors++; if (bus.in_V_TREADY !== 1'b0) begin miscompares++; $display("FAIL bp_tready got=%b exp=0", bus.in_V_TREADY); end
                vectors++; if (bus.out_acc !== 12'd2592 || bus.out_V_TDATA !== 1'b1)
                    begin miscompares++; $display("FAIL bp_hold got=%0d/%b exp=2592/1", bus.out_acc, bus.out_V_TDATA); end
                if (stalls == 5) bus.out_V_TREADY = 1'b1;
            end
            tick();
            if (accepted) b++;
            cycles++;
        end
        vectors++; if (stalls != 5 || b != FOLD) begin miscompares++; $display("FAIL bp_flow got=%0d stalls/%0d beats exp=5/%0d", stalls, b, FOLD); end
        drain();
        for (int n = 0; n < 2; n++) begin
            vectors++;
            if (got_acc.size() == 0 || exp_acc.size() == 0) begin miscompares++; $display("FAIL bp_missing n=%0d got=none exp=%0d/1", n, ka[n]); end
            else begin
                logic [ACC_W-1:0] ga, ea; logic gb, eb;
                ga = got_acc.pop_front(); gb = got_bit.pop_front();
                ea = exp_acc.pop_front(); eb = exp_bit.pop_front();
                if (ga !== ka[n] || gb !== 1'b1 || ga !== ea || gb !== eb)
                    begin miscompares++; $display("FAIL bp_result n=%0d got=%0d/%b exp=%0d/1", n, ga, gb, ka[n]); end
            end
        end
        exp_acc.delete(); exp_bit.delete(); got_acc.delete(); got_bit.delete();
    endtask

    task automatic test_reset_mid_neuron();
        bus.out_V_TREADY = 1'b1; bus.thr_V = 12'd5; bus.in_V_TDATA = ones_w;
        for (int i = 0; i < 4; i++) begin bus.in_V_TVALID = 1'b1; tick(); end
        bus.in_V_TVALID = 1'b0; ap_rst = 1'b1;
        tick();
        vectors++; if (bus.out_V_TVALID !== 1'b0 || bus.out_acc !== 12'd0 || bus.out_V_TDATA !== 1'b0 || bus.busy !== 1'b0 || bus.in_V_TREADY !== 1'b0)
            begin miscompares++; $display("FAIL midrst_outputs got=%b/%0d/%b/%b/%b exp=0/0/0/0/0", bus.out_V_TVALID, bus.out_acc, bus.out_V_TDATA, bus.busy, bus.in_V_TREADY); end
        ap_rst = 1'b0;
        bus.thr_V = 12'd1296; bus.in_V_TDATA = half_w;
        for (int i = 0; i < FOLD; i++) begin bus.in_V_TVALID = 1'b1; tick(); end
        drain();
        vectors++; if (got_acc.size() != 1) begin miscompares++; $display("FAIL midrst_count got=%0d exp=1", got_acc.size()); end
        if (got_acc.size() >= 1 && exp_acc.size() >= 1) begin
            logic [ACC_W-1:0] ga, ea; logic gb, eb;
            ga = got_acc.pop_front(); gb = got_bit.pop_front();
            ea = exp_acc.pop_front(); eb = exp_bit.pop_front();
            vectors++; if (ga !== 12'd1296 || gb !== 1'b1 || ga !== ea || gb !== eb)
                begin miscompares++; $display("FAIL midrst_result got=%0d/%b exp=1296/1", ga, gb); end
        end
        exp_acc.delete(); exp_bit.delete(); got_acc.delete(); got_bit.delete();
    endtask

    task automatic test_random();
        int total, acc_beats, cycles, nres;
        total = 12 * FOLD; acc_beats = 0; cycles = 0;
        while (acc_beats < total && cycles < 3000) begin
            for (int w = 0; w < SIMD / 32; w++) bus.in_V_TDATA[w*32 +: 32] = $urandom();
            if ($urandom_range(0, 3) == 0) bus.in_V_TDATA = bus.in_V_TDATA | {SIMD/2{2'b01}};
            case ($urandom_range(0, 5))
                0: bus.thr_V = 12'd0;
                1: bus.thr_V = 12'd2593;
                default: bus.thr_V = ACC_W'($urandom_range(1100, 1500));
            endcase
            bus.in_V_TVALID = ($urandom_range(0, 3) != 0);
            bus.out_V_TREADY = ($urandom_range(0, 2) != 0);
            tick();
            if (accepted) acc_beats++;
            cycles++;
        end
        vectors++; if (acc_beats != total) begin miscompares++; $display("FAIL rand_timeout got=%0d beats exp=%0d", acc_beats, total); end
        drain();
        nres = exp_acc.size();
        for (int n = 0; n < nres; n++) begin
            logic [ACC_W-1:0] ea; logic eb;
            ea = exp_acc.pop_front(); eb = exp_bit.pop_front();
            vectors++;
            if (got_acc.size() == 0) begin miscompares++; $display("FAIL rand_missing n=%0d got=none exp=%0d/%b", n, ea, eb); end
            else begin
                logic [ACC_W-1:0] ga; logic gb;
                ga = got_acc.pop_front(); gb = got_bit.pop_front();
                if (ga !== ea || gb !== eb) begin miscompares++; $display("FAIL rand_result n=%0d got=%0d/%b exp=%0d/%b", n, ga, gb, ea, eb); end
            end
        end
        vectors++; if (got_acc.size() != 0 || bus.busy !== 1'b0)
            begin miscompares++; $display("FAIL rand_idle got=%0d extra/busy=%b exp=0/0", got_acc.size(), bus.busy); end
        got_acc.delete(); got_bit.delete();
    endtask

    task automatic test_fold1();
        bus1.out_V_TREADY = 1'b1; bus1.in_V_TDATA = ones_w;
        bus1.in_V_TVALID = 1'b1; bus1.thr_V = 12'd289;
        @(posedge ap_clk); #1;
        bus1.thr_V = 12'd288;
        @(posedge ap_clk); #1;
        bus1.in_V_TVALID = 1'b0;
        vectors++; if (bus1.out_V_TVALID !== 1'b1 || bus1.out_acc !== 12'd288 || bus1.out_V_TDATA !== 1'b0)
            begin miscompares++; $display("FAIL fold1_first got=%b/%0d/%b exp=1/288/0", bus1.out_V_TVALID, bus1.out_acc, bus1.out_V_TDATA); end
        @(posedge ap_clk); #1;
        vectors++; if (bus1.out_V_TVALID !== 1'b1 || bus1.out_acc !== 12'd288 || bus1.out_V_TDATA !== 1'b1)
            begin miscompares++; $display("FAIL fold1_second got=%b/%0d/%b exp=1/288/1", bus1.out_V_TVALID, bus1.out_acc, bus1.out_V_TDATA); end
        @(posedge ap_clk); #1;
        vectors++; if (bus1.out_V_TVALID !== 1'b0 || bus1.busy !== 1'b0)
            begin miscompares++; $display("FAIL fold1_idle got=%b/%b exp=0/0", bus1.out_V_TVALID, bus1.busy); end
    endtask

    initial begin
        ones_w = {SIMD{1'b1}};
        zero_w = {SIMD{1'b0}};
        half_w = {(SIMD/8){8'hAA}};
        test_reset();
        test_all_ones();
        test_zero();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_neuron();
        test_random();
        test_fold1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
